// File: rtl/wave_gen_pkg.sv
// Shared types for the waveform generator: waveform/state enums, config set, LFSR and scaling helpers.
package wave_pkg;

  typedef enum logic [1:0] {SQUARE, SAW, TRI, NOISE} wave_sel_e;
  typedef enum logic [1:0] {IDLE, ARM, RUN, STOP} state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 as feedback taps on bits 7,5,4,3 of a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef struct packed {
    logic       en;
    wave_sel_e  wave;
    logic [15:0] inc;
    logic [7:0] amp;
    logic [7:0] duty;
  } cfg_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  // amp+1 keeps amp=0xFF as unity gain
  function automatic logic [7:0] scale(input logic [7:0] raw, input logic [7:0] amp);
    return 8'((17'(raw) * 17'({1'b0, amp} + 9'd1)) >> 8);
  endfunction

endpackage

// File: rtl/wave_gen_if.sv
// Configuration inputs and sample outputs of the waveform generator.
interface wave_gen_if;
  logic        cfg_wr_i;
  logic        cfg_en_i;
  logic [1:0]  cfg_wave_i;
  logic [15:0] cfg_inc_i;
  logic [7:0]  cfg_amp_i;
  logic [7:0]  cfg_duty_i;
  logic [7:0]  sample_o;
  logic        sample_vld_o;
  logic        sync_o;
  logic        busy_o;
  logic        pwm_o;

  modport master (
    output cfg_wr_i, cfg_en_i, cfg_wave_i, cfg_inc_i, cfg_amp_i, cfg_duty_i,
    input  sample_o, sample_vld_o, sync_o, busy_o, pwm_o
  );
  modport slave (
    input  cfg_wr_i, cfg_en_i, cfg_wave_i, cfg_inc_i, cfg_amp_i, cfg_duty_i,
    output sample_o, sample_vld_o, sync_o, busy_o, pwm_o
  );
endinterface

// File: rtl/wave_gen_pwm.sv
// PWM of the current sample; only built when WAVE_GEN_PWM_EN is defined.
`ifdef WAVE_GEN_PWM_EN
module wave_pwm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       busy,
  input  logic [7:0] sample,
  output logic       pwm
);
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else begin
      cnt <= busy ? cnt + 8'd1 : 8'd0;
      pwm <= (cnt < sample);
    end
  end
endmodule
`endif

// File: rtl/wave_gen.sv
// Phase-accumulator waveform generator with prescaled sample tick and start/stop FSM.
// Optional PWM output built when WAVE_GEN_PWM_EN is defined; otherwise pwm_o is 0.
module wave_gen
  import wave_pkg::*;
#(
  parameter int SAMPLE_DIV = 50,
  parameter int ACC_W      = 24
) (
  input logic       clk,
  input logic       rst_n,
  wave_gen_if.slave bus
);
  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(SAMPLE_DIV - 1);

  state_e         state;
  cfg_t           pend, act;
  logic [PW-1:0]  presc;
  logic           tick, first, busy;
  logic [ACC_W-1:0] acc;
  logic [7:0]     lfsr, sample, raw, phase;
  logic           vld, sync, pwm;
  logic [ACC_W:0] sum;
  logic           wrap;
  logic           unused;

  assign phase  = acc[ACC_W-1 -: 8];
  assign sum    = {1'b0, acc} + (ACC_W+1)'(act.inc);
  assign wrap   = tick & sum[ACC_W];
  assign unused = act.en;

  always_comb begin
    raw = 8'h00;
    unique case (act.wave)
      SQUARE: raw = (phase < act.duty) ? 8'hFF : 8'h00;
      SAW:    raw = phase;
      TRI:    raw = phase[7] ? ~{phase[6:0], 1'b0} : {phase[6:0], 1'b0};
      NOISE:  raw = lfsr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      pend   <= '0;
      act    <= '0;
      presc  <= '0;
      tick   <= 1'b0;
      acc    <= '0;
      lfsr   <= LFSR_SEED;
      first  <= 1'b0;
      sample <= '0;
      vld    <= 1'b0;
      sync   <= 1'b0;
    end else begin
      vld  <= 1'b0;
      sync <= 1'b0;
      if (bus.cfg_wr_i)
        pend <= '{en: bus.cfg_en_i, wave: wave_sel_e'(bus.cfg_wave_i), inc: bus.cfg_inc_i,
                  amp: bus.cfg_amp_i, duty: bus.cfg_duty_i};
      // config only switches at a period boundary, or freely while idle
      if (state == IDLE || wrap) act <= pend;

      if (state == IDLE) begin
        presc <= '0;
        tick  <= 1'b0;
      end else begin
        presc <= (presc == LAST) ? '0 : presc + PW'(1);
        tick  <= (presc == LAST);
      end

      if (tick) begin
        acc    <= sum[ACC_W-1:0];
        lfsr   <= lfsr_step(lfsr);
        sample <= scale(raw, act.amp);
        vld    <= 1'b1;
        sync   <= first;
        first  <= wrap;
      end

      unique case (state)
        IDLE: begin
          sample <= '0;
          if (bus.cfg_en_i) begin
            state <= ARM;
            busy  <= 1'b1;
            acc   <= '0;
            first <= 1'b1;
          end
        end
        ARM:  if (tick) state <= RUN;
        RUN:  if (!bus.cfg_en_i) state <= STOP;
        STOP: begin
          // zero increment would never wrap, so it stops on the next tick
          if (tick && (wrap || act.inc == '0)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bus.cfg_en_i) begin
            state <= RUN;
          end
        end
      endcase
    end
  end

`ifdef WAVE_GEN_PWM_EN
  wave_pwm u_pwm (.clk(clk), .rst_n(rst_n), .busy(busy), .sample(sample), .pwm(pwm));
`else
  assign pwm = 1'b0;
`endif

  assign bus.sample_o     = sample;
  assign bus.sample_vld_o = vld;
  assign bus.sync_o       = sync;
  assign bus.busy_o       = busy;
  assign bus.pwm_o        = pwm;

endmodule
